btb_update_unit: RTL and testbench



---
 rtl/rv32i_types_pkg.sv | 19 +
 rtl/btb_update_unit_queue.sv | 84 ++++++++
 rtl/btb_update_unit.sv | 93 +++++++++
 tb/tb_btb_update_unit.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_types_pkg.sv
// Shared RV32I front-end types: BTB geometry, the BTB update record and the
// single PC-to-BTB-index mapping used by fetch, the BTB and the update unit.
package rv32i_types;

  localparam int BTB_DEPTH = 64;
  localparam int BTB_IDX_W = $clog2(BTB_DEPTH);

  typedef struct packed {
    logic                 valid;
    logic [BTB_IDX_W-1:0] idx;
    logic [31:0]          target;
  } btb_upd_t;

  // Word-aligned PC; callers keep the low $clog2(depth) bits as the index.
  function automatic logic [31:0] pc_to_btb_idx(input logic [31:0] pc);
    return pc >> 2;
  endfunction

endpackage

// File: rtl/btb_update_unit_queue.sv
// Coalescing circular FIFO of pending BTB training writes. The head is drained
// every cycle it is occupied; pushes to an index already queued overwrite it.
module btb_upd_queue #(
  parameter int IDX_W     = 6,
  parameter int UPD_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [IDX_W-1:0] i_pushIdx,
  input  logic [31:0]      i_pushTarget,
  output logic             o_full,
  output logic             o_headValid,
  output logic [IDX_W-1:0] o_headIdx,
  output logic [31:0]      o_headTarget
);

  localparam int PTR_W = $clog2(UPD_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [UPD_DEPTH-1:0] r_valid;
  logic [IDX_W-1:0]     r_idx    [UPD_DEPTH];
  logic [31:0]          r_target [UPD_DEPTH];
  logic [PTR_W-1:0]     r_head;
  logic [PTR_W-1:0]     r_tail;
  logic [CNT_W-1:0]     r_count;

  logic             w_pop;
  logic             w_hit;
  logic [PTR_W-1:0] w_hitPtr;
  logic             w_alloc;
  logic             w_coalesce;

  // The head leaves this cycle, so it never absorbs a new update.
  always_comb begin
    w_hit    = 1'b0;
    w_hitPtr = '0;
    for (int i = 0; i < UPD_DEPTH; i++) begin
      if (r_valid[i] && (r_idx[i] == i_pushIdx) && (PTR_W'(i) != r_head)) begin
        w_hit    = 1'b1;
        w_hitPtr = PTR_W'(i);
      end
    end
  end

  assign w_pop      = (r_count != '0);
  assign w_alloc    = i_push & ~w_hit;
  assign w_coalesce = i_push & w_hit;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= '0;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_pop) begin
        r_valid[r_head] <= 1'b0;
        r_head          <= r_head + 1'b1;
      end
      if (w_alloc) begin
        r_valid[r_tail] <= 1'b1;
        r_tail          <= r_tail + 1'b1;
      end
      r_count <= r_count + CNT_W'(w_alloc) - CNT_W'(w_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (w_alloc) begin
      r_idx[r_tail]    <= i_pushIdx;
      r_target[r_tail] <= i_pushTarget;
    end
    if (w_coalesce) begin
      r_target[w_hitPtr] <= i_pushTarget;
    end
  end

  assign o_full       = (r_count == CNT_W'(UPD_DEPTH));
  assign o_headValid  = w_pop;
  assign o_headIdx    = w_pop ? r_idx[r_head] : '0;
  assign o_headTarget = w_pop ? r_target[r_head] : '0;

endmodule

// File: rtl/btb_update_unit.sv
// Compares predicted vs. resolved next PC, redirects fetch on a mismatch and
// queues the corresponding BTB training write; also keeps resolve statistics.
module btb_update_unit
  import rv32i_types::*;
#(
  parameter int BTB_DEPTH = rv32i_types::BTB_DEPTH,
  parameter int UPD_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         resolve_valid,
  output logic                         resolve_ready,
  input  logic [31:0]                  resolve_pc,
  input  logic [31:0]                  resolve_pred_pc,
  input  logic [31:0]                  resolve_actual_pc,
  output logic                         redirect_valid,
  output logic [31:0]                  redirect_pc,
  output logic                         pc_next_misprediction,
  output logic [$clog2(BTB_DEPTH)-1:0] btb_write_idx,
  output logic [31:0]                  btb_write_pc,
  output logic [31:0]                  stat_resolved,
  output logic [31:0]                  stat_mispredict
);

  localparam int IDX_W = $clog2(BTB_DEPTH);

  logic             w_full;
  logic             w_fire;
  logic             w_mis;
  logic [31:0]      w_idxWord;
  logic [IDX_W-1:0] w_idx;
  logic             w_unused;

  logic             r_redirectValid;
  logic [31:0]      r_redirectPc;
  logic [31:0]      r_statResolved;
  logic [31:0]      r_statMispredict;

  assign resolve_ready = ~w_full;
  assign w_fire        = resolve_valid & resolve_ready;
  assign w_mis         = w_fire & (resolve_pred_pc != resolve_actual_pc);
  assign w_idxWord     = pc_to_btb_idx(resolve_pc);
  assign w_idx         = w_idxWord[IDX_W-1:0];
  assign w_unused      = ^w_idxWord[31:IDX_W];

  btb_upd_queue #(
    .IDX_W     (IDX_W),
    .UPD_DEPTH (UPD_DEPTH)
  ) u_queue (
    .clk          (clk),
    .rst          (rst),
    .i_push       (w_mis),
    .i_pushIdx    (w_idx),
    .i_pushTarget (resolve_actual_pc),
    .o_full       (w_full),
    .o_headValid  (pc_next_misprediction),
    .o_headIdx    (btb_write_idx),
    .o_headTarget (btb_write_pc)
  );

  // redirect_pc keeps its last value between pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_redirectValid <= 1'b0;
      r_redirectPc    <= '0;
    end else begin
      r_redirectValid <= w_mis;
      if (w_mis) begin
        r_redirectPc <= resolve_actual_pc;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_statResolved   <= '0;
      r_statMispredict <= '0;
    end else begin
      if (w_fire && (r_statResolved != 32'hFFFF_FFFF)) begin
        r_statResolved <= r_statResolved + 32'd1;
      end
      if (w_mis && (r_statMispredict != 32'hFFFF_FFFF)) begin
        r_statMispredict <= r_statMispredict + 32'd1;
      end
    end
  end

  assign redirect_valid  = r_redirectValid;
  assign redirect_pc     = r_redirectPc;
  assign stat_resolved   = r_statResolved;
  assign stat_mispredict = r_statMispredict;

endmodule

// File: tb/tb_btb_update_unit.sv
// Self-checking bench for btb_update_unit: directed scenarios followed by
// random resolves, all compared each cycle against a queue-based reference.
module tb_btb_update_unit;

  localparam int BTB_DEPTH = 64;
  localparam int UPD_DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        resolve_valid;
  logic        resolve_ready;
  logic [31:0] resolve_pc;
  logic [31:0] resolve_pred_pc;
  logic [31:0] resolve_actual_pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        pc_next_misprediction;
  logic [5:0]  btb_write_idx;
  logic [31:0] btb_write_pc;
  logic [31:0] stat_resolved;
  logic [31:0] stat_mispredict;

  typedef struct {
    int unsigned idx;
    logic [31:0] target;
  } upd_t;

  upd_t        modelQ[$];
  logic        modelRedirValid;
  logic [31:0] modelRedirPc;
  logic [31:0] modelResolved;
  logic [31:0] modelMispredict;

  int checks = 0;
  int errors = 0;

  btb_update_unit #(
    .BTB_DEPTH (BTB_DEPTH),
    .UPD_DEPTH (UPD_DEPTH)
  ) dut (
    .clk                   (clk),
    .rst                   (rst),
    .resolve_valid         (resolve_valid),
    .resolve_ready         (resolve_ready),
    .resolve_pc            (resolve_pc),
    .resolve_pred_pc       (resolve_pred_pc),
    .resolve_actual_pc     (resolve_actual_pc),
    .redirect_valid        (redirect_valid),
    .redirect_pc           (redirect_pc),
    .pc_next_misprediction (pc_next_misprediction),
    .btb_write_idx         (btb_write_idx),
    .btb_write_pc          (btb_write_pc),
    .stat_resolved         (stat_resolved),
    .stat_mispredict       (stat_mispredict)
  );

  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, got, exp);
    end
  endtask

  // Compares every DUT output with the reference state for the current cycle.
  task automatic checkOutput();
    logic        expWen;
    logic [31:0] expIdx;
    logic [31:0] expPc;
    expWen = (modelQ.size() != 0);
    expIdx = expWen ? 32'(modelQ[0].idx) : 32'd0;
    expPc  = expWen ? modelQ[0].target : 32'd0;
    checkVal("resolve_ready", 32'(resolve_ready), 32'(modelQ.size() != UPD_DEPTH));
    checkVal("redirect_valid", 32'(redirect_valid), 32'(modelRedirValid));
    checkVal("redirect_pc", redirect_pc, modelRedirPc);
    checkVal("btb_wen", 32'(pc_next_misprediction), 32'(expWen));
    checkVal("btb_write_idx", 32'(btb_write_idx), expIdx);
    checkVal("btb_write_pc", btb_write_pc, expPc);
    checkVal("stat_resolved", stat_resolved, modelResolved);
    checkVal("stat_mispredict", stat_mispredict, modelMispredict);
  endtask

  task automatic modelReset();
    modelQ.delete();
    modelRedirValid = 1'b0;
    modelRedirPc    = 32'd0;
    modelResolved   = 32'd0;
    modelMispredict = 32'd0;
  endtask

  // Reference behaviour for one clock edge: head drains first, then a
  // mispredict either retargets a queued same-index update or appends one.
  task automatic modelStep(input logic r, input logic v, input logic [31:0] pc,
                           input logic [31:0] pred, input logic [31:0] act);
    bit          ready;
    bit          fire;
    bit          mis;
    bit          found;
    int unsigned idx;
    if (r) begin
      modelReset();
      return;
    end
    ready = (modelQ.size() != UPD_DEPTH);
    fire  = v && ready;
    mis   = fire && (pred != act);
    idx   = (pc >> 2) % BTB_DEPTH;
    modelRedirValid = mis;
    if (mis) modelRedirPc = act;
    if (fire && modelResolved != 32'hFFFF_FFFF) modelResolved++;
    if (mis && modelMispredict != 32'hFFFF_FFFF) modelMispredict++;
    if (modelQ.size() != 0) void'(modelQ.pop_front());
    if (mis) begin
      found = 0;
      foreach (modelQ[k]) begin
        if (modelQ[k].idx == idx) begin
          modelQ[k].target = act;
          found = 1;
        end
      end
      if (!found) modelQ.push_back('{idx: idx, target: act});
    end
  endtask

  // Drives one cycle of inputs (at the falling edge), checks, then advances.
  task automatic applyStimulus(input logic r, input logic v, input logic [31:0] pc,
                               input logic [31:0] pred, input logic [31:0] act);
    rst               = r;
    resolve_valid     = v;
    resolve_pc        = pc;
    resolve_pred_pc   = pred;
    resolve_actual_pc = act;
    #1;
    checkOutput();
    modelStep(r, v, pc, pred, act);
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] rpc;
    logic [31:0] rpred;
    logic [31:0] ract;
    logic        rv;
    int          mode;

    rst               = 1'b1;
    resolve_valid     = 1'b0;
    resolve_pc        = '0;
    resolve_pred_pc   = '0;
    resolve_actual_pc = '0;
    @(negedge clk);
    @(negedge clk);
    modelReset();
    $display("[TB] reset released");

    repeat (5) applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 32'h0);

    applyStimulus(1'b0, 1'b1, 32'h1000, 32'h1004, 32'h1004);
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 32'h0);

    applyStimulus(1'b0, 1'b1, 32'h1008, 32'h100C, 32'h2000);
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 32'h0);

    applyStimulus(1'b0, 1'b1, 32'h0000_000C, 32'h0, 32'hA000_0000);
    applyStimulus(1'b0, 1'b1, 32'h0000_0014, 32'h0, 32'hB000_0000);
    applyStimulus(1'b0, 1'b1, 32'h0000_0014, 32'h0, 32'hC000_0000);
    applyStimulus(1'b0, 1'b1, 32'h0000_001C, 32'h0, 32'hD000_0000);
    repeat (3) applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 32'h0);

    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, 1'b1, 32'h3000 + 32'(i * 4), 32'h1, 32'h5000 + 32'(i * 16));
    end
    repeat (2) applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 32'h0);

    applyStimulus(1'b0, 1'b1, 32'h0000_0100, 32'h0000_0000, 32'h8000_0000);
    applyStimulus(1'b0, 1'b1, 32'h0000_0104, 32'h0, 32'h1234_5678);
    applyStimulus(1'b1, 1'b1, 32'h0000_0108, 32'h0, 32'h9999_0000);
    repeat (2) applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 32'h0);

    for (int i = 0; i < 400; i++) begin
      mode  = int'($urandom_range(0, 3));
      rv    = ($urandom_range(0, 3) != 0);
      rpc   = ($urandom & 32'hFFFF_0000) | (32'($urandom_range(0, 7)) << 2) | 32'($urandom_range(0, 3));
      rpred = $urandom;
      case (mode)
        0:       ract = rpred;
        1:       ract = rpred ^ (32'd1 << $urandom_range(0, 31));
        default: ract = $urandom;
      endcase
      applyStimulus((i == 200), rv, rpc, rpred, ract);
    end
    repeat (3) applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
